// File: rtl/gpu_reset_sequencer_if.sv
// Signal bundle between the GPU reset sequencer and its environment.
// The slave modport is the sequencer's view; the master modport drives its inputs.
interface gpu_reset_sequencer_if;
    logic       locked;
    logic       btn_in;
    logic       heartbeat;
    logic       gpu_rst_n;
    logic       gpu_ena;
    logic [1:0] state_o;
    logic [7:0] restart_cnt;

    modport master (
        output locked,
        output btn_in,
        output heartbeat,
        input  gpu_rst_n,
        input  gpu_ena,
        input  state_o,
        input  restart_cnt
    );

    modport slave (
        input  locked,
        input  btn_in,
        input  heartbeat,
        output gpu_rst_n,
        output gpu_ena,
        output state_o,
        output restart_cnt
    );
endinterface

// File: rtl/gpu_reset_sequencer.sv
// GPU reset sequencer: waits for a stable clock lock, holds the GPU in reset, then enables it.
// Optional heartbeat watchdog is compiled in with the macro GPU_SEQ_WATCHDOG_EN.
module gpu_reset_sequencer #(
    parameter int unsigned LOCK_STABLE = 16,
    parameter int unsigned RST_HOLD    = 8,
    parameter int unsigned DEBOUNCE    = 4,
    parameter int unsigned WDT_TIMEOUT = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    gpu_reset_sequencer_if.slave  bus
);

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        STABLE    = 2'd1,
        HOLD_RST  = 2'd2,
        RUN       = 2'd3
    } state_t;

    localparam logic [15:0] STABLE_LAST = 16'(LOCK_STABLE - 1);
    localparam logic [15:0] HOLD_LAST   = 16'(RST_HOLD - 1);
    localparam logic [7:0]  DEB_LAST    = 8'(DEBOUNCE - 1);
    localparam logic [7:0]  RESTART_MAX = 8'hFF;

    logic        locked_meta_r;
    logic        locked_sync_r;
    logic        btn_meta_r;
    logic        btn_sync_r;
    logic [7:0]  deb_cnt_r;
    logic        btn_clean_s;
    state_t      state_r;
    state_t      state_next_s;
    logic [15:0] cnt_r;
    logic        cnt_clear_s;
    logic        gpu_rst_n_r;
    logic        gpu_ena_r;
    logic [7:0]  restart_cnt_r;

    // Two-flop synchronizers for the asynchronous lock and button pins.
    always_ff @(posedge clk) begin
        if (reset) begin
            locked_meta_r <= 1'b0;
            locked_sync_r <= 1'b0;
            btn_meta_r    <= 1'b0;
            btn_sync_r    <= 1'b0;
        end else begin
            locked_meta_r <= bus.locked;
            locked_sync_r <= locked_meta_r;
            btn_meta_r    <= bus.btn_in;
            btn_sync_r    <= btn_meta_r;
        end
    end

    // Debounce counter: counts consecutive high samples, saturating one short of acceptance.
    always_ff @(posedge clk) begin
        if (reset) begin
            deb_cnt_r <= 8'd0;
        end else if (!btn_sync_r) begin
            deb_cnt_r <= 8'd0;
        end else if (deb_cnt_r != DEB_LAST) begin
            deb_cnt_r <= deb_cnt_r + 8'd1;
        end else begin
            deb_cnt_r <= deb_cnt_r;
        end
    end

    // The current high sample completes the run, so a low sample drops btn_clean immediately.
    assign btn_clean_s = btn_sync_r && (deb_cnt_r == DEB_LAST);

`ifdef GPU_SEQ_WATCHDOG_EN
    localparam logic [15:0] WDT_LAST = 16'(WDT_TIMEOUT - 1);

    logic        hb_d_r;
    logic        hb_edge_s;
    logic [15:0] wdt_cnt_r;
    logic        wdt_expire_s;

    // Delayed heartbeat copy for edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            hb_d_r <= 1'b0;
        end else begin
            hb_d_r <= bus.heartbeat;
        end
    end

    assign hb_edge_s    = bus.heartbeat ^ hb_d_r;
    assign wdt_expire_s = (state_r == RUN) && (wdt_cnt_r == WDT_LAST);

    // Watchdog window counter; parked at zero outside RUN so every RUN entry starts fresh.
    always_ff @(posedge clk) begin
        if (reset) begin
            wdt_cnt_r <= 16'd0;
        end else if (state_r != RUN) begin
            wdt_cnt_r <= 16'd0;
        end else if (hb_edge_s || (state_next_s != RUN)) begin
            wdt_cnt_r <= 16'd0;
        end else begin
            wdt_cnt_r <= wdt_cnt_r + 16'd1;
        end
    end
`else
    logic unused_heartbeat_s;
    localparam int unsigned unused_wdt_timeout = WDT_TIMEOUT;

    assign unused_heartbeat_s = bus.heartbeat;
`endif

    // Next-state logic; lock loss is tested first in every state so it overrides all else.
    always_comb begin
        state_next_s = state_r;
        cnt_clear_s  = 1'b0;
        case (state_r)
            WAIT_LOCK: begin
                if (locked_sync_r) begin
                    state_next_s = STABLE;
                end else begin
                    state_next_s = WAIT_LOCK;
                end
            end
            STABLE: begin
                if (!locked_sync_r) begin
                    state_next_s = WAIT_LOCK;
                end else if (cnt_r == STABLE_LAST) begin
                    state_next_s = HOLD_RST;
                end else begin
                    state_next_s = STABLE;
                end
            end
            HOLD_RST: begin
                if (!locked_sync_r) begin
                    state_next_s = WAIT_LOCK;
                end else if (btn_clean_s) begin
                    state_next_s = HOLD_RST;
                    cnt_clear_s  = 1'b1;
                end else if (cnt_r == HOLD_LAST) begin
                    state_next_s = RUN;
                end else begin
                    state_next_s = HOLD_RST;
                end
            end
            RUN: begin
                if (!locked_sync_r) begin
                    state_next_s = WAIT_LOCK;
                end else if (btn_clean_s) begin
                    state_next_s = HOLD_RST;
`ifdef GPU_SEQ_WATCHDOG_EN
                end else if (wdt_expire_s) begin
                    state_next_s = HOLD_RST;
`endif
                end else begin
                    state_next_s = RUN;
                end
            end
            default: begin
                state_next_s = WAIT_LOCK;
            end
        endcase
    end

    // State register and per-state dwell counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= WAIT_LOCK;
            cnt_r   <= 16'd0;
        end else begin
            state_r <= state_next_s;
            if ((state_next_s != state_r) || cnt_clear_s) begin
                cnt_r <= 16'd0;
            end else begin
                cnt_r <= cnt_r + 16'd1;
            end
        end
    end

    // Outputs decoded from the next state so the flops track the state register exactly.
    always_ff @(posedge clk) begin
        if (reset) begin
            gpu_rst_n_r <= 1'b0;
            gpu_ena_r   <= 1'b0;
        end else begin
            gpu_rst_n_r <= (state_next_s == RUN);
            gpu_ena_r   <= (state_next_s == RUN);
        end
    end

    // Saturating count of RUN exits; reset has priority so an aborted RUN is not counted.
    always_ff @(posedge clk) begin
        if (reset) begin
            restart_cnt_r <= 8'd0;
        end else if ((state_r == RUN) && (state_next_s != RUN) && (restart_cnt_r != RESTART_MAX)) begin
            restart_cnt_r <= restart_cnt_r + 8'd1;
        end else begin
            restart_cnt_r <= restart_cnt_r;
        end
    end

    assign bus.gpu_rst_n   = gpu_rst_n_r;
    assign bus.gpu_ena     = gpu_ena_r;
    assign bus.state_o     = state_r;
    assign bus.restart_cnt = restart_cnt_r;

endmodule

// File: tb/tb_gpu_reset_sequencer.sv
// Self-checking bench for gpu_reset_sequencer: vector table plus hand sequences, scoreboard-checked.
module tb_gpu_reset_sequencer;

    logic clk = 1'b0;
    logic reset;

    gpu_reset_sequencer_if bus ();

    gpu_reset_sequencer #(
        .LOCK_STABLE (16),
        .RST_HOLD    (8),
        .DEBOUNCE    (4),
        .WDT_TIMEOUT (64)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst_n;
        logic       ena;
        logic [1:0] st;
        logic [7:0] rc;
        string      name;
    } exp_t;

    typedef struct {
        logic locked;
        logic btn;
        logic hb;
        int   cycles;
        exp_t exp;
    } vec_t;

    exp_t sb_q[$];
    vec_t vtab[$];
    int   errors = 0;
    int   checks = 0;
    int   rc_base;

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_exp(input string name, input logic r, input logic e,
                            input logic [1:0] s, input logic [7:0] c);
        exp_t x;
        x.name  = name;
        x.rst_n = r;
        x.ena   = e;
        x.st    = s;
        x.rc    = c;
        sb_q.push_back(x);
    endtask

    task automatic pop_check();
        exp_t x;
        checks++;
        if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty: no expectation queued");
        end else begin
            x = sb_q.pop_front();
            if ((bus.gpu_rst_n !== x.rst_n) || (bus.gpu_ena !== x.ena) ||
                (bus.state_o !== x.st) || (bus.restart_cnt !== x.rc)) begin
                errors++;
                $display("FAIL %s: got rst_n=%0b ena=%0b state=%0d restart=%0d, want rst_n=%0b ena=%0b state=%0d restart=%0d",
                         x.name, bus.gpu_rst_n, bus.gpu_ena, bus.state_o, bus.restart_cnt,
                         x.rst_n, x.ena, x.st, x.rc);
            end
        end
    endtask

    task automatic expect_after(input int n, input string name, input logic r, input logic e,
                                input logic [1:0] s, input logic [7:0] c);
        push_exp(name, r, e, s, c);
        cyc(n);
        pop_check();
    endtask

    task automatic add_vec(input logic l, input logic b, input logic h, input int n,
                           input logic r, input logic e, input logic [1:0] s,
                           input logic [7:0] c, input string name);
        vec_t v;
        v.locked    = l;
        v.btn       = b;
        v.hb        = h;
        v.cycles    = n;
        v.exp.rst_n = r;
        v.exp.ena   = e;
        v.exp.st    = s;
        v.exp.rc    = c;
        v.exp.name  = name;
        vtab.push_back(v);
    endtask

    initial begin
        // Cycle counts are edges after the input change: sync 2, WAIT_LOCK exit 1, STABLE 16, HOLD 8.
        add_vec(1'b1, 1'b0, 1'b0,  1, 1'b0, 1'b0, 2'd0, 8'd0, "bring_sync");
        add_vec(1'b1, 1'b0, 1'b0,  2, 1'b0, 1'b0, 2'd1, 8'd0, "bring_stable");
        add_vec(1'b1, 1'b0, 1'b0, 15, 1'b0, 1'b0, 2'd1, 8'd0, "bring_stable_end");
        add_vec(1'b1, 1'b0, 1'b0,  1, 1'b0, 1'b0, 2'd2, 8'd0, "bring_hold");
        add_vec(1'b1, 1'b0, 1'b0,  7, 1'b0, 1'b0, 2'd2, 8'd0, "bring_hold_end");
        add_vec(1'b1, 1'b0, 1'b0,  1, 1'b1, 1'b1, 2'd3, 8'd0, "bring_run_27");
        add_vec(1'b1, 1'b1, 1'b0,  3, 1'b1, 1'b1, 2'd3, 8'd0, "btn_short_hi");
        add_vec(1'b1, 1'b0, 1'b0,  6, 1'b1, 1'b1, 2'd3, 8'd0, "btn_short_lo");
        add_vec(1'b1, 1'b1, 1'b0,  5, 1'b1, 1'b1, 2'd3, 8'd0, "btn_long_pre");
        add_vec(1'b1, 1'b1, 1'b0,  1, 1'b0, 1'b0, 2'd2, 8'd1, "btn_long_hold");
        add_vec(1'b1, 1'b1, 1'b0,  4, 1'b0, 1'b0, 2'd2, 8'd1, "btn_long_held");
        add_vec(1'b1, 1'b0, 1'b0,  9, 1'b0, 1'b0, 2'd2, 8'd1, "btn_release_hold");
        add_vec(1'b1, 1'b0, 1'b0,  1, 1'b1, 1'b1, 2'd3, 8'd1, "btn_rerun");

        reset         = 1'b1;
        bus.locked    = 1'b0;
        bus.btn_in    = 1'b0;
        bus.heartbeat = 1'b0;
        expect_after(1, "reset_first_edge", 1'b0, 1'b0, 2'd0, 8'd0);
        expect_after(2, "reset_held", 1'b0, 1'b0, 2'd0, 8'd0);
        reset = 1'b0;
        expect_after(4, "idle_no_lock", 1'b0, 1'b0, 2'd0, 8'd0);

        for (int i = 0; i < vtab.size(); i++) begin
            bus.locked    = vtab[i].locked;
            bus.btn_in    = vtab[i].btn;
            bus.heartbeat = vtab[i].hb;
            push_exp(vtab[i].exp.name, vtab[i].exp.rst_n, vtab[i].exp.ena,
                     vtab[i].exp.st, vtab[i].exp.rc);
            cyc(vtab[i].cycles);
            pop_check();
        end

        // Reset in RUN aborts without counting; lock stays high so release restarts bring-up.
        reset = 1'b1;
        expect_after(1, "reset_in_run", 1'b0, 1'b0, 2'd0, 8'd0);
        reset = 1'b0;
        cyc(24);
        bus.locked = 1'b0;
        expect_after(2, "simul_hold_cnt7", 1'b0, 1'b0, 2'd2, 8'd0);
        expect_after(1, "simul_lock_drop", 1'b0, 1'b0, 2'd0, 8'd0);
        expect_after(10, "simul_no_run", 1'b0, 1'b0, 2'd0, 8'd0);

        // One-cycle lock glitch seen by the FSM while STABLE cnt=10.
        bus.locked = 1'b1;
        cyc(11);
        bus.locked = 1'b0;
        cyc(1);
        bus.locked = 1'b1;
        expect_after(1, "glitch_stable", 1'b0, 1'b0, 2'd1, 8'd0);
        expect_after(1, "glitch_lost", 1'b0, 1'b0, 2'd0, 8'd0);
        expect_after(24, "glitch_hold_26", 1'b0, 1'b0, 2'd2, 8'd0);
        expect_after(1, "glitch_run_27", 1'b1, 1'b1, 2'd3, 8'd0);

`ifdef GPU_SEQ_WATCHDOG_EN
        for (int i = 0; i < 5; i++) begin
            bus.heartbeat = ~bus.heartbeat;
            expect_after(40, "wdt_kicked", 1'b1, 1'b1, 2'd3, 8'd0);
        end
        expect_after(24, "wdt_pre_expire", 1'b1, 1'b1, 2'd3, 8'd0);
        expect_after(1, "wdt_expire", 1'b0, 1'b0, 2'd2, 8'd1);
        expect_after(8, "wdt_rerun", 1'b1, 1'b1, 2'd3, 8'd1);
        rc_base = 1;
`else
        for (int i = 0; i < 3; i++) begin
            bus.heartbeat = ~bus.heartbeat;
            expect_after(40, "hb_ignored", 1'b1, 1'b1, 2'd3, 8'd0);
        end
        expect_after(2000, "hb_stopped_run", 1'b1, 1'b1, 2'd3, 8'd0);
        rc_base = 0;
`endif

        // Forced button restarts drive restart_cnt into saturation.
        for (int i = 0; i < 300; i++) begin
            bus.btn_in = 1'b1;
            cyc(6);
            bus.btn_in = 1'b0;
            cyc(12);
            if (i == 9) begin
                expect_after(0, "restart_count_10", 1'b1, 1'b1, 2'd3, 8'(rc_base + 10));
            end
        end
        expect_after(0, "restart_saturated", 1'b1, 1'b1, 2'd3, 8'd255);

        reset = 1'b1;
        expect_after(1, "sat_reset_in_run", 1'b0, 1'b0, 2'd0, 8'd0);
        expect_after(2, "sat_reset_held", 1'b0, 1'b0, 2'd0, 8'd0);
        reset = 1'b0;
        expect_after(26, "post_reset_hold", 1'b0, 1'b0, 2'd2, 8'd0);
        expect_after(1, "post_reset_run", 1'b1, 1'b1, 2'd3, 8'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
